ula_acumulador: RTL and testbench
=================================

ULA_ACUMULADOR -- requirements
Module: ula_acumulador

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK input 1 (rising edge), then CLR input 1 (asynchronous, active-high).
REQ-002 The block SHALL have bus_in, input, 8 bits: shared data bus value, from RAM, the operand field or the switches.
REQ-003 The block SHALL have Eu, Ea, La and Lb, each an input of 1 bit: ALU output enable, accumulator output enable, accumulator load and B-register load.
REQ-004 The block SHALL have Add, Sub, AndOp, OrOp, XorOp and NotOp, each an input of 1 bit: ALU operation selects, one-hot.
REQ-005 The block SHALL have bus_out, output, 8 bits: value driven toward the bus; bus_oe, output, 1 bit: bus_out is valid.
REQ-006 The block SHALL have acc, output, 8 bits: accumulator contents, to the output register and debug.
REQ-007 The block SHALL have flag_z and flag_c, outputs of 1 bit: zero flag and carry/no-borrow flag.
REQ-008 The block SHALL have op_err and bus_conflict, outputs of 1 bit: sticky control-fault indicators.
REQ-009 The block SHALL have wb_count, output, 8 bits: count of ALU write-backs.

Function
REQ-010 The B register SHALL capture bus_in on the CLK rising edge when Lb=1, and SHALL hold otherwise.
REQ-011 The ALU SHALL be combinational on the registered A and B values:
- Add: A+B mod 256; carry = bit 8.
- Sub: A-B mod 256; carry = 1 when A>=B (no borrow).
- AndOp: A&B. OrOp: A|B. XorOp: A^B.
- NotOp: ~A, with B ignored.
- Carry SHALL be 0 for all logic operations.
REQ-012 If the operation selects are not exactly one-hot, the ALU result SHALL be 0x00 and carry SHALL be 0.
REQ-013 On a rising edge with La=1, A SHALL load the ALU result if Eu=1, and bus_in otherwise. This is a one-cycle read-modify-write.
REQ-014 Flags SHALL update only on an ALU write-back edge (La=1 and Eu=1):
- flag_z = (result == 0).
- flag_c = ALU carry.
- On all other edges both flags SHALL hold.
REQ-015 wb_count SHALL increment by 1 on every ALU write-back edge and SHALL wrap from 255 to 0.
REQ-016 Bus drive SHALL be combinational:
- Eu=1: bus_out = ALU result.
- Else Ea=1: bus_out = A.
- Else: bus_out = 0x00.
- bus_oe = Eu|Ea.
REQ-017 op_err SHALL set on any edge where Eu=1 and the operation selects are not one-hot, and SHALL stay set until reset.
REQ-018 bus_conflict SHALL set on any edge where Eu=1 and Ea=1, and SHALL stay set until reset. Eu keeps priority on the bus in that case.
REQ-019 Simultaneous La and Lb SHALL both take effect on the same edge. A's new value SHALL use B's old value.
REQ-020 acc SHALL always equal the registered A value.

Reset
REQ-021 CLR=1 SHALL immediately force A, B, flag_z, flag_c, op_err, bus_conflict and wb_count to 0, regardless of CLK.
REQ-022 While CLR=1 the block SHALL ignore all loads. The first capture SHALL happen on the first rising edge after CLR falls.
REQ-023 An assertion of CLR in the middle of an instruction SHALL discard any pending write-back. No flag or counter SHALL update on that edge.

Structure
REQ-024 A shared package SHALL hold:
- DATA_W = 8.
- The SAP-1 opcode constants: ADD 0100, SUB 0101, AND 0110, OR 0111, XOR 1000, NOT 1001, JMP 1010.
The control unit and this block SHALL share the package.
REQ-025 The combinational ALU (REQ-011 and REQ-012) SHALL be a sub-module named ula_comb. Registers, bus muxing and fault logic SHALL stay in ula_acumulador.

Verification
REQ-026 Add with overflow: load B=0x01 and A=0xFF (La with bus_in), then Eu+Add+La -> acc=0x00, flag_z=1, flag_c=1, wb_count=1.
REQ-027 Sub with borrow: A=0x03, B=0x05, Eu+Sub+La -> acc=0xFE, flag_z=0, flag_c=0; then A=0x05, B=0x05, Sub -> acc=0x00, flag_z=1, flag_c=1.
REQ-028 NOT and flag hold: A=0x0F, Eu+NotOp+La -> acc=0xF0, flag_c=0; next edge with La=1, Eu=0, bus_in=0x00 -> acc=0x00 and flags unchanged (flag_z stays 0).
REQ-029 Faults: Eu+Add+Sub+La with A=0x12 -> acc=0x00 and op_err=1 sticky; Eu=Ea=1 -> bus_out = ALU result, bus_conflict=1; both stay 1 until CLR.
REQ-030 Reset during write-back: with wb_count=0xFF, assert CLR asynchronously in the cycle of an Eu+Add+La edge -> all outputs 0 at once; with no reset, the 256th write-back wraps wb_count to 0x00.

Source files
------------

// File: rtl/ula_acumulador_pkg.sv
// ----------------------------------------------------------------------------
// ula_acumulador_pkg
// Shared definitions for the SAP-1 datapath and its control unit:
//   DATA_W        - datapath width
//   opcode_t      - SAP-1 instruction opcodes decoded by the control unit
//   alu_sel_t     - ALU operation select vector, bit 0 = Add ... bit 5 = NotOp
//   SEL_*         - the six legal one-hot select patterns
// ----------------------------------------------------------------------------
package ula_acumulador_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned N_ALU_OPS = 6;

    typedef enum logic [3:0] {
        OPC_ADD = 4'b0100,
        OPC_SUB = 4'b0101,
        OPC_AND = 4'b0110,
        OPC_OR  = 4'b0111,
        OPC_XOR = 4'b1000,
        OPC_NOT = 4'b1001,
        OPC_JMP = 4'b1010
    } opcode_t;

    typedef logic [N_ALU_OPS-1:0] alu_sel_t;

    localparam alu_sel_t SEL_ADD = 6'b000001;
    localparam alu_sel_t SEL_SUB = 6'b000010;
    localparam alu_sel_t SEL_AND = 6'b000100;
    localparam alu_sel_t SEL_OR  = 6'b001000;
    localparam alu_sel_t SEL_XOR = 6'b010000;
    localparam alu_sel_t SEL_NOT = 6'b100000;

    function automatic logic sel_is_onehot(input alu_sel_t s);
        return $onehot(s);
    endfunction

endpackage

// File: rtl/ula_comb.sv
// ----------------------------------------------------------------------------
// ula_comb
// Purely combinational ALU operating on the registered A and B values.
//   i_a, i_b   : operands
//   i_sel      : operation select (must be one-hot, see package SEL_*)
//   o_result   : operation result, 0x00 when i_sel is not one-hot
//   o_carry    : Add carry-out / Sub no-borrow; 0 for logic ops and bad selects
//   o_onehot   : i_sel is a legal one-hot pattern
// ----------------------------------------------------------------------------
module ula_comb
    import ula_acumulador_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_sel_t          i_sel,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_onehot
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign o_onehot = sel_is_onehot(i_sel);

    // Any pattern other than the six legal ones falls to default, which
    // covers both "no select" and "several selects".
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_sel)
            SEL_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            SEL_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                // Extended subtraction wraps negative exactly when A < B.
                o_carry  = ~w_diff[DATA_W];
            end
            SEL_AND: o_result = i_a & i_b;
            SEL_OR:  o_result = i_a | i_b;
            SEL_XOR: o_result = i_a ^ i_b;
            SEL_NOT: o_result = ~i_a;
            default: begin
                o_result = '0;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_acumulador.sv
// ----------------------------------------------------------------------------
// ula_acumulador
// SAP-1 accumulator (A), B register, ALU, bus driver and fault monitors.
//   CLK, CLR       : clock (rising edge), asynchronous active-high clear
//   bus_in         : shared data bus value
//   Eu / Ea        : drive ALU result / accumulator onto the bus
//   La / Lb        : load A / load B
//   Add..NotOp     : one-hot ALU operation selects
//   bus_out/bus_oe : bus drive value and its valid strobe
//   acc            : registered A
//   flag_z/flag_c  : zero / carry flags, updated on ALU write-back only
//   op_err         : sticky, Eu seen with a non one-hot select
//   bus_conflict   : sticky, Eu and Ea seen together
//   wb_count       : wrapping count of ALU write-backs
// ----------------------------------------------------------------------------
module ula_acumulador
    import ula_acumulador_pkg::*;
(
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              Eu,
    input  logic              Ea,
    input  logic              La,
    input  logic              Lb,
    input  logic              Add,
    input  logic              Sub,
    input  logic              AndOp,
    input  logic              OrOp,
    input  logic              XorOp,
    input  logic              NotOp,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [DATA_W-1:0] acc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              op_err,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] wb_count
);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_z;
    logic              r_c;
    logic              r_op_err;
    logic              r_bus_conflict;
    logic [DATA_W-1:0] r_wb_count;

    alu_sel_t          w_sel;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_onehot;
    logic              w_writeback;

    assign w_sel       = {NotOp, XorOp, OrOp, AndOp, Sub, Add};
    assign w_writeback = La & Eu;

    ula_comb u_ula_comb (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sel    (w_sel),
        .o_result (w_result),
        .o_carry  (w_carry),
        .o_onehot (w_onehot)
    );

    // The ALU reads the pre-edge B, so a simultaneous La/Lb computes A from
    // the old B while B captures the new bus value.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_a            <= '0;
            r_b            <= '0;
            r_z            <= 1'b0;
            r_c            <= 1'b0;
            r_op_err       <= 1'b0;
            r_bus_conflict <= 1'b0;
            r_wb_count     <= '0;
        end else begin
            if (Lb) begin
                r_b <= bus_in;
            end
            if (La) begin
                r_a <= Eu ? w_result : bus_in;
            end
            if (w_writeback) begin
                r_z        <= (w_result == '0);
                r_c        <= w_carry;
                r_wb_count <= r_wb_count + 1'b1;
            end
            if (Eu && !w_onehot) begin
                r_op_err <= 1'b1;
            end
            if (Eu && Ea) begin
                r_bus_conflict <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_out = '0;
        if (Eu) begin
            bus_out = w_result;
        end else if (Ea) begin
            bus_out = r_a;
        end
    end

    assign bus_oe       = Eu | Ea;
    assign acc          = r_a;
    assign flag_z       = r_z;
    assign flag_c       = r_c;
    assign op_err       = r_op_err;
    assign bus_conflict = r_bus_conflict;
    assign wb_count     = r_wb_count;

endmodule

// File: tb/tb_ula_acumulador.sv
module tb_ula_acumulador;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [7:0] bus_in = '0;
    logic       Eu = 1'b0, Ea = 1'b0, La = 1'b0, Lb = 1'b0;
    logic       Add = 1'b0, Sub = 1'b0, AndOp = 1'b0, OrOp = 1'b0, XorOp = 1'b0, NotOp = 1'b0;
    logic [7:0] bus_out, acc, wb_count;
    logic       bus_oe, flag_z, flag_c, op_err, bus_conflict;

    ula_acumulador dut (
        .CLK(CLK), .CLR(CLR), .bus_in(bus_in),
        .Eu(Eu), .Ea(Ea), .La(La), .Lb(Lb),
        .Add(Add), .Sub(Sub), .AndOp(AndOp), .OrOp(OrOp), .XorOp(XorOp), .NotOp(NotOp),
        .bus_out(bus_out), .bus_oe(bus_oe), .acc(acc),
        .flag_z(flag_z), .flag_c(flag_c), .op_err(op_err),
        .bus_conflict(bus_conflict), .wb_count(wb_count)
    );

    always #5 CLK = ~CLK;

    localparam logic [5:0] S_ADD = 6'b000001, S_SUB = 6'b000010, S_AND = 6'b000100;
    localparam logic [5:0] S_OR  = 6'b001000, S_XOR = 6'b010000, S_NOT = 6'b100000;
    localparam logic [5:0] S_NONE = 6'b000000;

    typedef struct {
        int a, z, c, err, conf, cnt, bus, oe;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state, plain integers
    int m_a = 0, m_b = 0, m_z = 0, m_c = 0, m_err = 0, m_conf = 0, m_cnt = 0;

    // Arithmetic reference for the ALU
    function automatic void alu_ref(input int a, input int b, input logic [5:0] sel,
                                    output int r, output int c);
        r = 0;
        c = 0;
        if ($countones(sel) != 1) return;
        if (sel[0]) begin
            r = a + b;
            c = (r > 255) ? 1 : 0;
            r = r % 256;
        end else if (sel[1]) begin
            c = (a >= b) ? 1 : 0;
            r = (a - b + 256) % 256;
        end else if (sel[2]) r = a & b;
        else if (sel[3]) r = a | b;
        else if (sel[4]) r = a ^ b;
        else r = 255 - a;
    endfunction

    function automatic void push_expect(input bit eu, input bit ea, input logic [5:0] sel);
        exp_t e;
        int r, c;
        alu_ref(m_a, m_b, sel, r, c);
        e.a = m_a; e.z = m_z; e.c = m_c; e.err = m_err; e.conf = m_conf; e.cnt = m_cnt;
        e.bus = eu ? r : (ea ? m_a : 0);
        e.oe  = (eu || ea) ? 1 : 0;
        q.push_back(e);
    endfunction

    task automatic apply(input bit la, input bit lb, input bit eu, input bit ea,
                         input logic [5:0] sel, input int bin);
        {NotOp, XorOp, OrOp, AndOp, Sub, Add} = sel;
        La = la; Lb = lb; Eu = eu; Ea = ea;
        bus_in = bin[7:0];
    endtask

    // One clocked cycle: drive on negedge, advance the model, queue expectation
    task automatic drive(input bit la, input bit lb, input bit eu, input bit ea,
                         input logic [5:0] sel, input int bin);
        int r, c;
        @(negedge CLK);
        CLR = 1'b0;
        apply(la, lb, eu, ea, sel, bin);
        alu_ref(m_a, m_b, sel, r, c);
        if (eu && $countones(sel) != 1) m_err = 1;
        if (eu && ea) m_conf = 1;
        if (la) begin
            if (eu) begin
                m_a = r; m_z = (r == 0) ? 1 : 0; m_c = c; m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_a = bin;
            end
        end
        if (lb) m_b = bin;
        push_expect(eu, ea, sel);
    endtask

    // CLR raised mid-cycle; either dropped again before the edge or held across it
    task automatic reset_pulse(input bit hold, input bit la, input bit eu, input logic [5:0] sel);
        @(negedge CLK);
        apply(la, 1'b0, eu, 1'b0, sel, 8'hA5);
        #2 CLR = 1'b1;
        m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_err = 0; m_conf = 0; m_cnt = 0;
        push_expect(eu, 1'b0, sel);
        if (!hold) #1 CLR = 1'b0;
    endtask

    function automatic void cmp(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares the oldest expectation after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("acc",          {24'b0, acc},          e.a);
                cmp("flag_z",       {31'b0, flag_z},       e.z);
                cmp("flag_c",       {31'b0, flag_c},       e.c);
                cmp("op_err",       {31'b0, op_err},       e.err);
                cmp("bus_conflict", {31'b0, bus_conflict}, e.conf);
                cmp("wb_count",     {24'b0, wb_count},     e.cnt);
                cmp("bus_out",      {24'b0, bus_out},      e.bus);
                cmp("bus_oe",       {31'b0, bus_oe},       e.oe);
            end
        end
    end

    initial begin
        logic [5:0] s;
        int drain;

        // Reset state, and an asynchronous pulse fully inside one cycle
        drive(0, 0, 0, 0, S_NONE, 0);
        drive(1, 1, 0, 0, S_NONE, 8'h77);
        reset_pulse(0, 0, 0, S_NONE);

        // Add with overflow
        drive(0, 1, 0, 0, S_NONE, 8'h01);
        drive(1, 0, 0, 0, S_NONE, 8'hFF);
        drive(1, 0, 1, 0, S_ADD, 8'h00);

        // Sub with and without borrow
        drive(1, 1, 0, 0, S_NONE, 8'h05);
        drive(1, 0, 0, 0, S_NONE, 8'h03);
        drive(1, 0, 1, 0, S_SUB, 8'h00);
        drive(1, 1, 0, 0, S_NONE, 8'h05);
        drive(1, 0, 1, 0, S_SUB, 8'h00);

        // La+Lb together: A uses old B
        drive(1, 0, 0, 0, S_NONE, 8'h03);
        drive(1, 1, 1, 0, S_ADD, 8'h10);
        drive(1, 0, 1, 0, S_ADD, 8'h00);

        // NOT, then plain load keeps flags
        drive(1, 0, 0, 0, S_NONE, 8'h0F);
        drive(1, 0, 1, 0, S_NOT, 8'h00);
        drive(1, 0, 0, 0, S_NONE, 8'h00);
        drive(0, 0, 0, 1, S_NONE, 8'h00);
        drive(1, 0, 1, 0, S_AND, 8'h00);
        drive(1, 0, 1, 0, S_OR, 8'h00);
        drive(1, 0, 1, 0, S_XOR, 8'h00);

        // Faults, sticky until reset
        drive(1, 0, 0, 0, S_NONE, 8'h12);
        drive(1, 0, 1, 0, S_ADD | S_SUB, 8'h00);
        drive(1, 0, 0, 0, S_NONE, 8'h40);
        drive(0, 0, 1, 1, S_XOR, 8'h00);
        drive(1, 0, 0, 0, S_NONE, 8'h00);
        drive(0, 0, 0, 1, S_NONE, 8'h00);
        reset_pulse(0, 0, 0, S_NONE);

        // 255 write-backs, then CLR held over the next write-back edge
        for (int i = 0; i < 255; i++) drive(1, 0, 1, 0, S_ADD, 0);
        reset_pulse(1, 1, 1, S_ADD);
        // 256 write-backs without reset wrap the counter
        drive(1, 1, 0, 0, S_NONE, 8'h01);
        for (int i = 0; i < 256; i++) drive(1, 0, 1, 0, S_ADD, 0);

        // Randomized traffic
        reset_pulse(0, 0, 0, S_NONE);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) s = 6'($urandom_range(0, 63));
            else s = 6'(1) << $urandom_range(0, 5);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  s, int'($urandom_range(0, 255)));
        end

        drain = 0;
        while (q.size() != 0 && drain < 10) begin
            @(posedge CLK);
            drain++;
        end
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
